// File: rtl/obi_fetch_master.sv
// Instruction-fetch initiator for the OBI-style instr bus.
// Fetches sequential words from BOOT_ADDR (or a redirect target) into an
// in-order prefetch FIFO and presents them on a valid/ready interface.
// Ports:
//   clk, rst (async, active-low)
//   en_i, redirect_i, redirect_addr_i         : fetch control
//   instr_req_o/addr_o, instr_gnt_i           : bus address phase
//   instr_rvalid_i/rdata_i/err_i (+intg, unused): bus response phase
//   out_valid_o/ready_i/rdata_o/addr_o/err_o  : consumer side (FIFO head)
module obi_fetch_master #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h00000080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic [6:0]  instr_rdata_intg_i,
  input  logic        instr_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = 65;
  localparam logic [31:0] BOOT_WORD = {BOOT_ADDR[31:2], 2'b00};

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HALT} state_t;

  state_t          r_state;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [31:0]     r_fetch_addr;
  logic [31:0]     r_resp_addr;
  logic [31:0]     r_target;
  logic            r_pending;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [EW-1:0]   r_mem [DEPTH];
  logic            r_out_valid;
  logic [31:0]     r_out_rdata;
  logic [31:0]     r_out_addr;
  logic            r_out_err;

  state_t          w_state_nxt;
  logic            w_grant;
  logic            w_hold;
  logic            w_push;
  logic            w_pop;
  logic            w_start_boot;
  logic            w_pend_release;
  logic            w_pending_nxt;
  logic            w_credit_ok;
  logic            w_req_nxt;
  logic [31:0]     w_redir_tgt;
  logic [31:0]     w_fetch_nxt;
  logic [31:0]     w_resp_nxt;
  logic [31:0]     w_addr_nxt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_wptr_nxt;
  logic [PW-1:0]   w_rptr_nxt;
  logic [EW-1:0]   w_push_entry;
  logic [EW-1:0]   w_head_entry;
  logic            w_unused_intg;

  assign w_unused_intg = ^instr_rdata_intg_i;

  // Next-state, bookkeeping and request decision for the coming cycle
  always_comb begin
    w_grant        = r_req & instr_gnt_i;
    w_hold         = r_req & ~instr_gnt_i;
    w_push         = instr_rvalid_i & ~redirect_i & (r_discard == '0);
    w_pop          = r_out_valid & out_ready_i & ~redirect_i;
    w_redir_tgt    = {redirect_addr_i[31:2], 2'b00};
    w_start_boot   = (r_state == ST_IDLE) & en_i & ~redirect_i;
    w_pend_release = r_pending & w_grant & ~redirect_i;
    w_push_entry   = {instr_err_i, r_resp_addr, instr_rdata_i};

    w_state_nxt = r_state;
    if (redirect_i) begin
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE:  if (en_i) w_state_nxt = ST_FETCH;
        ST_FETCH: if (w_push && instr_err_i) w_state_nxt = ST_HALT;
        ST_HALT:  w_state_nxt = ST_HALT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end

    // A request held at redirect keeps its address; the target is issued after its grant
    w_fetch_nxt = r_fetch_addr;
    w_resp_nxt  = r_resp_addr;
    if (redirect_i) begin
      if (!w_hold) begin
        w_fetch_nxt = w_redir_tgt;
        w_resp_nxt  = w_redir_tgt;
      end
    end else if (w_pend_release) begin
      w_fetch_nxt = r_target;
      w_resp_nxt  = r_target;
    end else if (w_start_boot) begin
      w_fetch_nxt = BOOT_WORD;
      w_resp_nxt  = BOOT_WORD;
    end else begin
      if (w_grant) w_fetch_nxt = r_fetch_addr + 32'd4;
      if (w_push)  w_resp_nxt  = r_resp_addr + 32'd4;
    end

    w_pending_nxt = redirect_i ? w_hold : (w_pend_release ? 1'b0 : r_pending);

    w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(instr_rvalid_i);

    // Every response still owed at redirect is thrown away, as is the held request's
    if (redirect_i) begin
      w_discard_nxt = w_outstanding_nxt;
    end else begin
      w_discard_nxt = r_discard + CW'(r_pending & w_grant)
                    - CW'(instr_rvalid_i & (r_discard != '0));
    end

    if (redirect_i) begin
      w_count_nxt = '0;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_wptr_nxt  = r_wptr + PW'(w_push);
      w_rptr_nxt  = r_rptr + PW'(w_pop);
    end

    // Credit: FIFO slots already promised to in-flight responses are not reusable
    w_credit_ok = (SW'(w_count_nxt) + SW'(w_outstanding_nxt)) < SW'(DEPTH);
    w_req_nxt   = w_hold | ((w_state_nxt == ST_FETCH) & en_i & ~w_pending_nxt & w_credit_ok);
    w_addr_nxt  = (!w_hold && w_req_nxt) ? w_fetch_nxt : r_addr;

    // Head after this edge: bypass the word being written if it lands at the new head
    w_head_entry = (w_push && (r_wptr == w_rptr_nxt)) ? w_push_entry : r_mem[w_rptr_nxt];
  end

  // FIFO storage (no reset needed; validity is tracked by r_count)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_entry;
  end

  // FSM, bus request and FIFO control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_req         <= 1'b0;
      r_addr        <= '0;
      r_fetch_addr  <= '0;
      r_resp_addr   <= '0;
      r_target      <= '0;
      r_pending     <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_out_valid   <= 1'b0;
      r_out_rdata   <= '0;
      r_out_addr    <= '0;
      r_out_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_addr        <= w_addr_nxt;
      r_fetch_addr  <= w_fetch_nxt;
      r_resp_addr   <= w_resp_nxt;
      if (redirect_i) r_target <= w_redir_tgt;
      r_pending     <= w_pending_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      r_count       <= w_count_nxt;
      r_wptr        <= w_wptr_nxt;
      r_rptr        <= w_rptr_nxt;
      r_out_valid   <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_out_err   <= w_head_entry[64];
        r_out_addr  <= w_head_entry[63:32];
        r_out_rdata <= w_head_entry[31:0];
      end
    end
  end

  assign instr_req_o  = r_req;
  assign instr_addr_o = r_addr;
  assign out_valid_o  = r_out_valid;
  assign out_rdata_o  = r_out_rdata;
  assign out_addr_o   = r_out_addr;
  assign out_err_o    = r_out_err;

endmodule

// File: tb/tb_obi_fetch_master.sv
// Directed bench for obi_fetch_master with a small boot-ROM responder model.
module tb_obi_fetch_master;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic [6:0]  instr_rdata_intg_i;
  logic        instr_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Responder configuration
  int          lat;
  int          stall_target;
  int          stall_seen;
  logic        any_addr;
  logic        err_en;
  logic [31:0] err_addr;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } pop_t;

  pop_t        pop_q[$];
  logic [31:0] gnt_q[$];

  obi_fetch_master #(.DEPTH(4), .BOOT_ADDR(32'h00000080)) dut (
    .clk                (clk),
    .rst                (rst),
    .en_i               (en_i),
    .redirect_i         (redirect_i),
    .redirect_addr_i    (redirect_addr_i),
    .instr_req_o        (instr_req_o),
    .instr_addr_o       (instr_addr_o),
    .instr_gnt_i        (instr_gnt_i),
    .instr_rvalid_i     (instr_rvalid_i),
    .instr_rdata_i      (instr_rdata_i),
    .instr_rdata_intg_i (instr_rdata_intg_i),
    .instr_err_i        (instr_err_i),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .out_rdata_o        (out_rdata_o),
    .out_addr_o         (out_addr_o),
    .out_err_o          (out_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00000080: rom_word = 32'h00000513;
      32'h00000084: rom_word = 32'h000015b7;
      32'h00000088: rom_word = 32'h00a58223;
      32'h0000008C: rom_word = 32'h00150513;
      32'h00000090: rom_word = 32'hff9ff06f;
      default:      rom_word = a ^ 32'hA5A50000;
    endcase
  endfunction

  // Responder: combinational grant, response after 1 or 2 cycles
  logic [1:0]  rsp_v;
  logic [1:0]  rsp_e;
  logic [31:0] rsp_d0;
  logic [31:0] rsp_d1;

  assign instr_gnt_i = instr_req_o && (any_addr || (instr_addr_o < 32'h100))
                       && (stall_seen >= stall_target);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_seen <= 0;
    end else if (instr_req_o && (stall_seen < stall_target)) begin
      stall_seen <= stall_seen + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_v  <= '0;
      rsp_e  <= '0;
      rsp_d0 <= '0;
      rsp_d1 <= '0;
    end else begin
      rsp_v[1] <= rsp_v[0];
      rsp_e[1] <= rsp_e[0];
      rsp_d1   <= rsp_d0;
      rsp_v[0] <= instr_req_o && instr_gnt_i;
      rsp_e[0] <= err_en && (instr_addr_o == err_addr);
      rsp_d0   <= rom_word(instr_addr_o);
    end
  end

  assign instr_rvalid_i = (lat == 2) ? rsp_v[1] : rsp_v[0];
  assign instr_err_i    = (lat == 2) ? rsp_e[1] : rsp_e[0];
  assign instr_rdata_i  = (lat == 2) ? rsp_d1   : rsp_d0;

  // Monitor: record grants and consumer handshakes mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (instr_req_o && instr_gnt_i) gnt_q.push_back(instr_addr_o);
      if (out_valid_o && out_ready_i && !redirect_i)
        pop_q.push_back({out_err_o, out_addr_o, out_rdata_o});
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    en_i = 1'b0;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    out_ready_i = 1'b1;
    instr_rdata_intg_i = '0;
    any_addr = 1'b0;
    err_en = 1'b0;
    err_addr = '0;
    stall_target = 0;
    lat = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    gnt_q.delete();
    pop_q.delete();
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pop_q.size() >= n) break;
      @(posedge clk);
      #1;
    end
    if (pop_q.size() >= n) ok = 1'b1;
  endtask

  task automatic redirect_pulse(input logic [31:0] a);
    redirect_i = 1'b1;
    redirect_addr_i = a;
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({instr_req_o, instr_addr_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o} !== '0) begin
      $display("FAIL reset_outputs: req=%b addr=%h vld=%b data=%h oaddr=%h err=%b expected all 0",
               instr_req_o, instr_addr_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o);
      n_fail++;
    end
  endtask

  task automatic test_boot_sequence();
    logic [31:0] exp_a [5];
    logic [31:0] exp_d [5];
    bit ok;
    exp_a = '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h90};
    exp_d = '{32'h00000513, 32'h000015b7, 32'h00a58223, 32'h00150513, 32'hff9ff06f};
    do_reset();
    en_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      $display("FAIL boot_latency_early: out_valid=%b expected 0", out_valid_o); n_fail++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b1 || out_addr_o !== 32'h80) begin
      $display("FAIL boot_latency: out_valid=%b addr=%h expected 1/00000080", out_valid_o, out_addr_o);
      n_fail++;
    end
    wait_pops(5, 60, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL boot_wait: pops=%0d expected 5", pop_q.size()); n_fail++; end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (pop_q[i] !== {1'b0, exp_a[i], exp_d[i]}) begin
        $display("FAIL boot_word%0d: got err=%b addr=%h data=%h expected 0/%h/%h",
                 i, pop_q[i].err, pop_q[i].addr, pop_q[i].data, exp_a[i], exp_d[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    out_ready_i = 1'b0;
    en_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt_q.size() !== 4) begin
      $display("FAIL bp_grant_count: got %0d expected 4", gnt_q.size()); n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gnt_q[i] !== 32'h80 + 32'(4 * i)) begin
        $display("FAIL bp_grant%0d: got %h expected %h", i, gnt_q[i], 32'h80 + 32'(4 * i)); n_fail++;
      end
    end
    n_cmp++;
    if (instr_req_o !== 1'b0 || out_valid_o !== 1'b1 || out_addr_o !== 32'h80) begin
      $display("FAIL bp_stalled: req=%b vld=%b addr=%h expected 0/1/00000080",
               instr_req_o, out_valid_o, out_addr_o);
      n_fail++;
    end
    out_ready_i = 1'b1;
    wait_pops(8, 80, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL bp_wait: pops=%0d expected 8", pop_q.size()); n_fail++; end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (pop_q[i].addr !== 32'h80 + 32'(4 * i) || pop_q[i].data !== rom_word(32'h80 + 32'(4 * i))) begin
        $display("FAIL bp_word%0d: got addr=%h data=%h expected %h/%h", i, pop_q[i].addr,
                 pop_q[i].data, 32'h80 + 32'(4 * i), rom_word(32'h80 + 32'(4 * i)));
        n_fail++;
      end
    end
    n_cmp++;
    if (gnt_q[4] !== 32'h90) begin
      $display("FAIL bp_resume_addr: got %h expected 00000090", gnt_q[4]); n_fail++;
    end
  endtask

  task automatic test_gnt_stall();
    bit ok;
    do_reset();
    stall_target = 5;
    en_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80 || instr_gnt_i !== 1'b0) begin
        $display("FAIL stall_hold%0d: req=%b addr=%h gnt=%b expected 1/00000080/0",
                 i, instr_req_o, instr_addr_o, instr_gnt_i);
        n_fail++;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80 || gnt_q.size() !== 0) begin
      $display("FAIL stall_release: req=%b addr=%h grants=%0d expected 1/00000080/0",
               instr_req_o, instr_addr_o, gnt_q.size());
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (gnt_q.size() !== 1 || instr_rvalid_i !== 1'b1) begin
      $display("FAIL stall_one_outstanding: grants=%0d rvalid=%b expected 1/1", gnt_q.size(), instr_rvalid_i);
      n_fail++;
    end
    wait_pops(2, 30, ok);
    n_cmp++;
    if (!ok || pop_q[0].addr !== 32'h80 || pop_q[1].addr !== 32'h84) begin
      $display("FAIL stall_words: pops=%0d a0=%h a1=%h expected 00000080/00000084",
               pop_q.size(), pop_q[0].addr, pop_q[1].addr);
      n_fail++;
    end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    lat = 2;
    out_ready_i = 1'b0;
    en_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt_q.size() !== 4) begin
      $display("FAIL redir_pre_grants: got %0d expected 4", gnt_q.size()); n_fail++;
    end
    redirect_pulse(32'h00000087);
    n_cmp++;
    if (out_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h84) begin
      $display("FAIL redir_flush: vld=%b req=%b addr=%h expected 0/1/00000084",
               out_valid_o, instr_req_o, instr_addr_o);
      n_fail++;
    end
    out_ready_i = 1'b1;
    wait_pops(2, 40, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL redir_wait: pops=%0d expected 2", pop_q.size()); n_fail++; end
    n_cmp++;
    if (pop_q[0] !== {1'b0, 32'h84, 32'h000015b7} || pop_q[1].addr !== 32'h88) begin
      $display("FAIL redir_words: got %h/%h then %h expected 00000084/000015b7 then 00000088",
               pop_q[0].addr, pop_q[0].data, pop_q[1].addr);
      n_fail++;
    end
    n_cmp++;
    if (gnt_q[4] !== 32'h84) begin
      $display("FAIL redir_next_req: got %h expected 00000084", gnt_q[4]); n_fail++;
    end
  endtask

  task automatic test_error_halt();
    bit ok;
    do_reset();
    err_en = 1'b1;
    err_addr = 32'h88;
    en_i = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (pop_q.size() !== 4 || gnt_q.size() !== 4 || instr_req_o !== 1'b0) begin
      $display("FAIL err_halt: pops=%0d grants=%0d req=%b expected 4/4/0",
               pop_q.size(), gnt_q.size(), instr_req_o);
      n_fail++;
    end
    n_cmp++;
    if (pop_q[2] !== {1'b1, 32'h88, 32'h00a58223} || pop_q[1].err !== 1'b0) begin
      $display("FAIL err_word: got err=%b addr=%h data=%h expected 1/00000088/00a58223",
               pop_q[2].err, pop_q[2].addr, pop_q[2].data);
      n_fail++;
    end
    n_cmp++;
    if (pop_q[3] !== {1'b0, 32'h8C, 32'h00150513}) begin
      $display("FAIL err_inflight: got err=%b addr=%h expected 0/0000008c", pop_q[3].err, pop_q[3].addr);
      n_fail++;
    end
    err_en = 1'b0;
    gnt_q.delete();
    pop_q.delete();
    redirect_pulse(32'h80);
    wait_pops(1, 30, ok);
    n_cmp++;
    if (!ok || pop_q[0] !== {1'b0, 32'h80, 32'h00000513} || gnt_q[0] !== 32'h80) begin
      $display("FAIL err_restart: pops=%0d addr=%h data=%h grant=%h expected 00000080/00000513/00000080",
               pop_q.size(), pop_q[0].addr, pop_q[0].data, gnt_q[0]);
      n_fail++;
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    bit ok;
    exp_a = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
    exp_d = '{32'h5A5AFFF8, 32'h5A5AFFFC, 32'hA5A50000};
    do_reset();
    any_addr = 1'b1;
    en_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    redirect_pulse(32'hFFFFFFF8);
    gnt_q.delete();
    pop_q.delete();
    wait_pops(3, 30, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL wrap_wait: pops=%0d expected 3", pop_q.size()); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (gnt_q[i] !== exp_a[i] || pop_q[i] !== {1'b0, exp_a[i], exp_d[i]}) begin
        $display("FAIL wrap_word%0d: grant=%h pop=%h/%h expected %h/%h", i, gnt_q[i],
                 pop_q[i].addr, pop_q[i].data, exp_a[i], exp_d[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready_i = 1'b0;
    en_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    n_cmp++;
    if (out_valid_o !== 1'b1) begin
      $display("FAIL midrst_pre: out_valid=%b expected 1", out_valid_o); n_fail++;
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({instr_req_o, instr_addr_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o} !== '0) begin
      $display("FAIL midrst_outputs: req=%b addr=%h vld=%b data=%h oaddr=%h err=%b expected all 0",
               instr_req_o, instr_addr_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o);
      n_fail++;
    end
    en_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    en_i = 1'b0;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    out_ready_i = 1'b1;
    instr_rdata_intg_i = '0;
    any_addr = 1'b0;
    err_en = 1'b0;
    err_addr = '0;
    stall_target = 0;
    lat = 1;
    test_reset();
    test_boot_sequence();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_error_halt();
    test_addr_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
